data_memory_param: RTL and testbench
====================================

DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 Parameter DATA_W, default 256: memory line width in bits; a multiple of 8, and DATA_W/8 is a power of two.
REQ-002 Parameter ADDR_W, default 32: byte address width.
REQ-003 Parameter DEPTH, default 512: number of lines; a power of two, at least 2.
REQ-004 Parameter LATENCY, default 10: clock edges from request acceptance to ack; at least 1.
REQ-005 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  reset; synchronous and active-low.
REQ-007 addr_i  input  ADDR_W  byte address of the request.
REQ-008 data_i  input  DATA_W  write data.
REQ-009 enable_i  input  1  request valid.
REQ-010 write_i  input  1  1 = write, 0 = read; sampled with enable_i.
REQ-011 ack_o  output  1  one-cycle completion pulse.
REQ-012 data_o  output  DATA_W  read data.
REQ-013 busy_o  output  1  high whenever state is not IDLE.
REQ-014 rd_cnt_o  output  32  completed-read count.
REQ-015 wr_cnt_o  output  32  completed-write count.

Function
REQ-016 Line index SHALL be addr_i[LSB +: log2(DEPTH)], where LSB = log2(DATA_W/8).
- Upper address bits are ignored; addresses wrap modulo DEPTH lines.
- Low LSB bits are ignored (line-aligned access).
REQ-017 FSM states SHALL be IDLE, WAIT, ACK; it resets to IDLE.
REQ-018 Acceptance: at an edge with state IDLE and enable_i=1, the block SHALL latch the index, data_i and write_i, load the down-counter with LATENCY-1, and enter WAIT.
REQ-019 WAIT SHALL decrement the counter each edge and enter ACK at the edge where the counter equals 0.
- Result: ack_o is high from edge E0+LATENCY to E0+LATENCY+1, where E0 is the acceptance edge.
REQ-020 ACK SHALL return to IDLE unconditionally at the next edge.
- Requests are never accepted in WAIT or ACK.
- Earliest next acceptance is edge E0+LATENCY+2.
REQ-021 ack_o SHALL be registered and high for exactly one cycle per accepted request.
REQ-022 Writes SHALL update memory at the edge entering ACK, using the latched data and index.
- data_o is unchanged by writes.
REQ-023 Reads SHALL load data_o at the edge entering ACK with the line at the latched index.
- data_o holds that value until the next read completes.
REQ-024 Input changes after acceptance SHALL have no effect on the pending request; this includes enable_i deasserting.
REQ-025 A read completing after a write to the same index SHALL return the written data.

Reset
REQ-026 While rst_i=0 at an edge, the block SHALL force:
- state to IDLE,
- ack_o to 0 and busy_o to 0,
- data_o to 0 and the counter to 0,
- rd_cnt_o and wr_cnt_o to 0.
REQ-027 Reset during WAIT or ACK SHALL abort the request with no memory write and no ack.
REQ-028 Reset SHALL NOT clear memory contents.

Configuration
REQ-029 Macro DATA_MEMORY_STATS_EN defined: rd_cnt_o and wr_cnt_o SHALL increment at each completed read or write (the edge entering ACK).
- Both counters saturate at 32'hFFFFFFFF.
REQ-030 Macro DATA_MEMORY_STATS_EN undefined: rd_cnt_o and wr_cnt_o SHALL be constant 0 and no counter flops are built.

Verification
REQ-031 Defaults; write addr 0x20 with data 0xA5 and enable held 1 cycle -> ack_o high exactly at edge E0+10 for 1 cycle; then read 0x20 -> data_o = 0xA5 with ack.
REQ-032 LATENCY=1: read accepted at E0 -> ack_o and data_o valid from E1 to E2; busy_o high E0 to E2.
REQ-033 Defaults; write 0x4020 (index 1, wraps with DEPTH=512 lines) -> read 0x0020 returns the written data.
REQ-034 enable_i held high continuously with reads -> acks spaced exactly LATENCY+2 cycles apart; no extra acks.
REQ-035 rst_i=0 for one cycle at E0+5 during a write to 0x40 -> no ack; a later read of 0x40 returns the prior contents; busy_o=0 after reset.
REQ-036 DATA_MEMORY_STATS_EN defined; 3 reads and 2 writes -> rd_cnt_o=3, wr_cnt_o=2; with the macro undefined -> both 0.

Source files
------------

// File: rtl/data_memory_param.sv
// Line-addressed data memory with a fixed request-to-ack latency and a single outstanding request.
// Optional completed-read/write counters are built when DATA_MEMORY_STATS_EN is defined.
module data_memory_param #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam int LSB   = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdat_q;
  logic               wr_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic accept, complete;
  logic addr_unused;

  // Only the line-index field of the address is decoded.
  assign addr_unused = ^addr_i;

  assign accept   = (state == IDLE) && enable_i;
  assign complete = (state == WAIT) && (cnt == '0);
  assign busy_o   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable_i) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      ack_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= complete;
      if (accept)
        cnt <= CNT_W'(LATENCY - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (complete && !wr_q)
        data_o <= mem[idx_q];
    end
  end

  // Request capture; held stable until completion regardless of input changes.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q  <= addr_i[LSB +: IDX_W];
      wdat_q <= data_i;
      wr_q   <= write_i;
    end
  end

  // Memory is never reset; a reset mid-request suppresses the write.
  always_ff @(posedge clk_i) begin
    if (rst_i && complete && wr_q)
      mem[idx_q] <= wdat_q;
  end

`ifdef DATA_MEMORY_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else if (complete) begin
      if (wr_q) begin
        if (wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + 1'b1;
      end else begin
        if (rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + 1'b1;
      end
    end
  end
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: a default-latency instance and a LATENCY=1 instance,
// checked against a timestamp-based model every cycle plus directed literal expectations.
module tb_data_memory_param;

  localparam int DW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] din  [2];
  logic          en   [2];
  logic          wr   [2];
  logic          ack  [2];
  logic [DW-1:0] dout [2];
  logic          busy [2];
  logic [31:0]   rdc  [2];
  logic [31:0]   wrc  [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  data_memory_param u_dut0 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0]), .data_i(din[0]), .enable_i(en[0]),
    .write_i(wr[0]), .ack_o(ack[0]), .data_o(dout[0]), .busy_o(busy[0]),
    .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0]));

  data_memory_param #(.LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[1]), .data_i(din[1]), .enable_i(en[1]),
    .write_i(wr[1]), .ack_o(ack[1]), .data_o(dout[1]), .busy_o(busy[1]),
    .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1]));

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 10 : 1;
  endfunction

  // Model: each request is a timestamp; it completes LATENCY edges after acceptance
  // and the block is idle again one edge later.
  int          cyc = 0;
  bit          pend   [2];
  int          due    [2];
  bit          m_wr   [2];
  int          m_idx  [2];
  logic [DW-1:0] m_wd [2];
  logic [DW-1:0] m_dout [2];
  bit          m_dknown [2];
  bit          m_ack  [2];
  int unsigned m_rc [2];
  int unsigned m_wc [2];
  logic [DW-1:0] mmem [int];

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = 1'b0;
      if (!rst) begin
        pend[k] = 1'b0; m_dout[k] = '0; m_dknown[k] = 1'b1; m_rc[k] = 0; m_wc[k] = 0;
      end else if (pend[k] && cyc == due[k]) begin
        m_ack[k] = 1'b1;
        if (m_wr[k]) begin
          mmem[k*512 + m_idx[k]] = m_wd[k];
          if (m_wc[k] != 32'hFFFFFFFF) m_wc[k]++;
        end else begin
          m_dknown[k] = mmem.exists(k*512 + m_idx[k]);
          if (m_dknown[k]) m_dout[k] = mmem[k*512 + m_idx[k]];
          if (m_rc[k] != 32'hFFFFFFFF) m_rc[k]++;
        end
      end else if (pend[k] && cyc == due[k] + 1) begin
        pend[k] = 1'b0;
      end else if (!pend[k] && en[k]) begin
        pend[k]  = 1'b1;
        due[k]   = cyc + lat(k);
        m_wr[k]  = wr[k];
        m_idx[k] = (int'(addr[k]) / 32) % 512;
        m_wd[k]  = din[k];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ack%0d c%0d", k, cyc), DW'(ack[k]), DW'(m_ack[k]));
        chk($sformatf("busy%0d c%0d", k, cyc), DW'(busy[k]), DW'(pend[k]));
        if (m_dknown[k]) chk($sformatf("data%0d c%0d", k, cyc), dout[k], m_dout[k]);
`ifdef DATA_MEMORY_STATS_EN
        chk($sformatf("rdcnt%0d", k), DW'(rdc[k]), DW'(m_rc[k]));
        chk($sformatf("wrcnt%0d", k), DW'(wrc[k]), DW'(m_wc[k]));
`else
        chk($sformatf("rdcnt%0d", k), DW'(rdc[k]), '0);
        chk($sformatf("wrcnt%0d", k), DW'(wrc[k]), '0);
`endif
      end
    end
  end

  // One request with enable held for a single cycle; returns at the negedge after the ack edge.
  task automatic xact(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit w, input int exp_lat);
    int n;
    @(negedge clk);
    addr[k] = a; din[k] = d; wr[k] = w; en[k] = 1'b1;
    @(negedge clk);
    en[k] = 1'b0; addr[k] = '1; din[k] = '1; wr[k] = ~w;
    n = 0;
    while (!ack[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency%0d", k), DW'(n), DW'(exp_lat));
  endtask

  int acks[$];
  int cnt;

  initial begin
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; din[k] = '0; en[k] = 1'b0; wr[k] = 1'b0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst ack", DW'(ack[0]), '0);
    chk("rst busy", DW'(busy[0]), '0);
    chk("rst data", dout[0], '0);
    chk("rst data1", dout[1], '0);
    rst = 1'b1;

    // Default latency write/read of 0x20
    xact(0, 32'h20, DW'(8'hA5), 1'b1, 10);
    xact(0, 32'h20, '0, 1'b0, 10);
    chk("rd 0x20", dout[0], DW'(8'hA5));

    // LATENCY=1 instance
    xact(1, 32'h20, DW'(8'h5A), 1'b1, 1);
    xact(1, 32'h20, '0, 1'b0, 1);
    chk("lat1 data", dout[1], DW'(8'h5A));
    chk("lat1 busy at ack", DW'(busy[1]), DW'(1));

    // Address wrap: 0x4020 aliases line 1 like 0x0020
    xact(0, 32'h4020, {DW/32{32'hC0DE_0001}}, 1'b1, 10);
    xact(0, 32'h0020, '0, 1'b0, 10);
    chk("wrap data", dout[0], {DW/32{32'hC0DE_0001}});

    // Enable held continuously: acks every LATENCY+2 cycles
    @(negedge clk);
    addr[0] = 32'h20; wr[0] = 1'b0; en[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack[0]) acks.push_back(i);
    end
    en[0] = 1'b0;
    chk("stream ack count", DW'(acks.size()), DW'(4));
    for (int i = 1; i < acks.size(); i++)
      chk("stream gap", DW'(acks[i] - acks[i-1]), DW'(12));
    repeat (15) @(negedge clk);

    // Reset mid-write aborts it
    xact(0, 32'h40, DW'(32'hD1D1_D1D1), 1'b1, 10);
    @(negedge clk);
    addr[0] = 32'h40; din[0] = DW'(32'hD2D2_D2D2); wr[0] = 1'b1; en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("busy after rst", DW'(busy[0]), '0);
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack[0]) cnt++;
    end
    chk("no ack after rst", DW'(cnt), '0);
    xact(0, 32'h40, '0, 1'b0, 10);
    chk("rd after abort", dout[0], DW'(32'hD1D1_D1D1));

    // Counters: 2 writes and 3 reads on the fast instance
    xact(1, 32'h60, DW'(16'h6060), 1'b1, 1);
    xact(1, 32'h80, DW'(16'h8080), 1'b1, 1);
    xact(1, 32'h60, '0, 1'b0, 1);
    chk("rd 0x60", dout[1], DW'(16'h6060));
    xact(1, 32'h80, '0, 1'b0, 1);
    chk("rd 0x80", dout[1], DW'(16'h8080));
    xact(1, 32'h60, '0, 1'b0, 1);
    @(negedge clk);
`ifdef DATA_MEMORY_STATS_EN
    chk("rd_cnt", DW'(rdc[1]), DW'(3));
    chk("wr_cnt", DW'(wrc[1]), DW'(2));
`else
    chk("rd_cnt", DW'(rdc[1]), DW'(0));
    chk("wr_cnt", DW'(wrc[1]), DW'(0));
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
